dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp_if.sv | 27 ++
 rtl/dmem_resp.sv | 111 +++++++++++
 tb/tb_dmem_resp.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_resp_if.sv
// Request/response bus between a load/store unit and the data memory.
// The master issues requests; the slave (dmem_resp) answers them.
interface dmem_resp_if;
  logic        acs_en;
  logic        acs_wr;
  logic [7:0]  acs_bytes;
  logic [63:0] acs_addr;
  logic [63:0] acs_wdata;
  logic        acs_ready;
  logic        acs_rvalid;
  logic [63:0] acs_rdata;
  logic        acs_err;

  modport master (
    output acs_en, acs_wr, acs_bytes,
    output acs_addr, acs_wdata,
    input  acs_ready, acs_rvalid,
    input  acs_rdata, acs_err
  );

  modport slave (
    input  acs_en, acs_wr, acs_bytes,
    input  acs_addr, acs_wdata,
    output acs_ready, acs_rvalid,
    output acs_rdata, acs_err
  );
endinterface

// File: rtl/dmem_resp.sv
// Single-port 64-bit data memory with a one-cycle response.
// It accepts one request, answers in the next cycle, then idles.
module dmem_resp #(
  parameter int          DEPTH_LOG2 = 9,
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000
) (
  input logic       clk,
  input logic       rst_n,
  dmem_resp_if.slave acs
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t state_q, state_d;

  logic [63:0] mem [2**DEPTH_LOG2];

  logic [63:0] rel;
  logic [2:0]  off;
  logic [DEPTH_LOG2-1:0] idx;
  logic        size_ok;
  logic        align_bad;
  logic        range_bad;
  logic        err;
  logic        ready;
  logic        accept;
  logic [7:0]  lane;
  logic [63:0] wdata_sh;
  logic [63:0] bmask;
  logic [63:0] rdata_n;
  logic [63:0] rdata_q;
  logic        err_q;
  logic        unused;

  assign rel    = acs.acs_addr - BASE_ADDR;
  assign off    = acs.acs_addr[2:0];
  assign idx    = rel[DEPTH_LOG2+2:3];
  assign unused = ^rel[2:0];

  always_comb begin
    size_ok   = 1'b1;
    align_bad = 1'b0;
    unique case (acs.acs_bytes)
      8'h01:   align_bad = 1'b0;
      8'h03:   align_bad = off[0];
      8'h0F:   align_bad = |off[1:0];
      8'hFF:   align_bad = |off;
      default: size_ok   = 1'b0;
    endcase
  end

  // Full-width compare so addresses below base never wrap in
  assign range_bad = (acs.acs_addr < BASE_ADDR)
                   || (|rel[63:DEPTH_LOG2+3]);
  assign err = !size_ok || align_bad || range_bad;

  assign lane     = acs.acs_bytes << off;
  assign wdata_sh = acs.acs_wdata << {off, 3'b000};

  always_comb begin
    bmask = '0;
    for (int i = 0; i < 8; i++)
      bmask[8*i +: 8] = {8{acs.acs_bytes[i]}};
  end

  assign rdata_n = (mem[idx] >> {off, 3'b000}) & bmask;

  assign accept = rst_n && acs.acs_en && ready;

  always_ff @(posedge clk) begin
    if (accept && acs.acs_wr && !err) begin
      for (int i = 0; i < 8; i++)
        if (lane[i])
          mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        err_q   <= err;
        rdata_q <= (!err && !acs.acs_wr) ? rdata_n : '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (acs.acs_en) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset during RESP suppresses the pending response
  assign acs.acs_ready  = ready;
  assign acs.acs_rvalid = (state_q == RESP) && rst_n;
  assign acs.acs_rdata  = acs.acs_rvalid ? rdata_q : '0;
  assign acs.acs_err    = acs.acs_rvalid ? err_q : 1'b0;

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: a byte-level memory model predicts
// each response, and a negedge monitor compares every response strobe.
module tb_dmem_resp;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam int WORDS = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dmem_resp_if bus();

  dmem_resp #(
    .DEPTH_LOG2(9),
    .BASE_ADDR (BASE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .acs  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit mon_on = 1'b0;

  logic [63:0] sb_rdata[$];
  logic        sb_err[$];
  logic [63:0] model [WORDS];

  task automatic model_op(input logic wr, input logic [7:0] bytes,
                          input logic [63:0] addr,
                          input logic [63:0] wdata,
                          output logic [63:0] rd, output logic er);
    int n;
    int o;
    logic [63:0] r;
    int wi;
    rd = '0;
    er = 1'b0;
    o = int'(addr[2:0]);
    case (bytes)
      8'h01: n = 1;
      8'h03: n = 2;
      8'h0F: n = 4;
      8'hFF: n = 8;
      default: begin n = 0; er = 1'b1; end
    endcase
    if (n != 0 && (o % n) != 0) er = 1'b1;
    r = addr - BASE;
    if (addr < BASE || r >= 64'd4096) er = 1'b1;
    if (!er) begin
      wi = int'(r >> 3);
      for (int k = 0; k < n; k++) begin
        if (wr) model[wi][8*(o+k) +: 8] = wdata[8*k +: 8];
        else    rd[8*k +: 8] = model[wi][8*(o+k) +: 8];
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      total++;
      if (bus.acs_rvalid === 1'b1) begin
        if (sb_rdata.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rvalid: got rvalid=1 want no response");
        end else begin
          logic [63:0] er_d;
          logic        er_e;
          er_d = sb_rdata.pop_front();
          er_e = sb_err.pop_front();
          if (bus.acs_rdata !== er_d || bus.acs_err !== er_e) begin
            bad++;
            $display("FAIL resp: got rdata=%h err=%b want rdata=%h err=%b",
                     bus.acs_rdata, bus.acs_err, er_d, er_e);
          end
        end
      end else if (bus.acs_rvalid !== 1'b0
                   || bus.acs_rdata !== 64'd0
                   || bus.acs_err !== 1'b0) begin
        bad++;
        $display("FAIL idle_out: got rvalid=%b rdata=%h err=%b want 0 0 0",
                 bus.acs_rvalid, bus.acs_rdata, bus.acs_err);
      end
    end
  end

  // One isolated request; chk selects a fixed expectation over the model
  task automatic req(input logic wr, input logic [7:0] bytes,
                     input logic [63:0] addr, input logic [63:0] wdata,
                     input bit chk, input logic [63:0] x_rdata,
                     input logic x_err);
    logic [63:0] m_rd;
    logic        m_er;
    model_op(wr, bytes, addr, wdata, m_rd, m_er);
    sb_rdata.push_back(chk ? x_rdata : m_rd);
    sb_err.push_back(chk ? x_err : m_er);
    @(negedge clk);
    total++;
    if (bus.acs_ready !== 1'b1) begin
      bad++;
      $display("FAIL req_ready: got %b want 1", bus.acs_ready);
    end
    bus.acs_en    = 1'b1;
    bus.acs_wr    = wr;
    bus.acs_bytes = bytes;
    bus.acs_addr  = addr;
    bus.acs_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.acs_en = 1'b0;
    total++;
    if (bus.acs_rvalid !== 1'b1) begin
      bad++;
      $display("FAIL latency: got rvalid=%b want 1", bus.acs_rvalid);
    end
  endtask

  task automatic test_reset;
    bus.acs_en    = 1'b0;
    bus.acs_wr    = 1'b0;
    bus.acs_bytes = 8'h00;
    bus.acs_addr  = '0;
    bus.acs_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 4;
    if (bus.acs_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready: got %b want 1", bus.acs_ready);
    end
    if (bus.acs_rvalid !== 1'b0) begin
      bad++; $display("FAIL rst_rvalid: got %b want 0", bus.acs_rvalid);
    end
    if (bus.acs_rdata !== 64'd0) begin
      bad++; $display("FAIL rst_rdata: got %h want 0", bus.acs_rdata);
    end
    if (bus.acs_err !== 1'b0) begin
      bad++; $display("FAIL rst_err: got %b want 0", bus.acs_err);
    end
    rst_n = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic test_store_load;
    req(1, 8'hFF, BASE, 64'h1122334455667788, 1, 64'd0, 1'b0);
    req(0, 8'hFF, BASE, 64'd0, 1, 64'h1122334455667788, 1'b0);
  endtask

  task automatic test_byte_lanes;
    req(1, 8'h01, BASE + 64'd5, 64'hFFFF_FFFF_FFFF_FFAB, 1, 64'd0, 1'b0);
    req(0, 8'hFF, BASE, 64'd0, 1, 64'h1122AB4455667788, 1'b0);
    req(0, 8'h01, BASE + 64'd5, 64'd0, 1, 64'h00000000000000AB, 1'b0);
    req(0, 8'h03, BASE + 64'd6, 64'd0, 1, 64'h0000000000001122, 1'b0);
    req(0, 8'h0F, BASE + 64'd4, 64'd0, 1, 64'h000000001122AB44, 1'b0);
  endtask

  task automatic test_misalign;
    req(1, 8'h0F, BASE + 64'd2, 64'hCAFEBABE, 1, 64'd0, 1'b1);
    req(0, 8'hFF, BASE, 64'd0, 1, 64'h1122AB4455667788, 1'b0);
    req(0, 8'h03, BASE + 64'd1, 64'd0, 1, 64'd0, 1'b1);
    req(0, 8'hFF, BASE + 64'd4, 64'd0, 1, 64'd0, 1'b1);
    req(1, 8'h07, BASE, 64'd0, 1, 64'd0, 1'b1);
    req(0, 8'hFF, BASE, 64'd0, 1, 64'h1122AB4455667788, 1'b0);
  endtask

  task automatic test_range;
    req(0, 8'hFF, 64'h8000_1000, 64'd0, 1, 64'd0, 1'b1);
    req(0, 8'hFF, 64'h7FFF_FFF8, 64'd0, 1, 64'd0, 1'b1);
    req(1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFF8, 64'h55, 1, 64'd0, 1'b1);
    req(1, 8'hFF, 64'h8000_0FF8, 64'h0BAD_F00D_1234_5678, 1, 64'd0, 1'b0);
    req(0, 8'hFF, 64'h8000_0FF8, 64'd0, 1, 64'h0BAD_F00D_1234_5678, 1'b0);
    req(0, 8'hFF, BASE, 64'd0, 1, 64'h1122AB4455667788, 1'b0);
  endtask

  task automatic test_random;
    logic [7:0] sizes [5];
    logic [63:0] a;
    sizes[0] = 8'h01; sizes[1] = 8'h03; sizes[2] = 8'h0F;
    sizes[3] = 8'hFF; sizes[4] = 8'h05;
    for (int w = 1; w < 8; w++)
      req(1, 8'hFF, BASE + 64'(8*w), {$urandom, $urandom}, 0, 64'd0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      a = BASE + 64'(8*$urandom_range(1, 7)) + 64'($urandom_range(0, 7));
      req(1'($urandom_range(0, 1)), sizes[$urandom_range(0, 4)], a,
          {$urandom, $urandom}, 0, 64'd0, 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_rdy;
    logic [63:0] m_rd;
    logic        m_er;
    logic        wr_k;
    logic [7:0]  by_k;
    logic [63:0] ad_k;
    logic [63:0] wd_k;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_rdy = (k % 2 == 0);
      total++;
      if (bus.acs_ready !== exp_rdy) begin
        bad++;
        $display("FAIL b2b_ready: k=%0d got %b want %b",
                 k, bus.acs_ready, exp_rdy);
      end
      if (exp_rdy) begin
        wr_k = (k % 4 == 0);
        by_k = (k == 8) ? 8'h01 : 8'hFF;
        ad_k = BASE + 64'd48 + ((k == 8) ? 64'd3 : 64'd0);
        wd_k = 64'hA5A5_0000_0000_0000 | 64'(k);
      end else begin
        wr_k = 1'b1;
        by_k = 8'hFF;
        ad_k = BASE + 64'd56;
        wd_k = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      if (exp_rdy) begin
        model_op(wr_k, by_k, ad_k, wd_k, m_rd, m_er);
        sb_rdata.push_back(m_rd);
        sb_err.push_back(m_er);
      end
      bus.acs_en    = 1'b1;
      bus.acs_wr    = wr_k;
      bus.acs_bytes = by_k;
      bus.acs_addr  = ad_k;
      bus.acs_wdata = wd_k;
    end
    @(negedge clk);
    bus.acs_en = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (sb_rdata.size() != 0) begin
      bad++;
      $display("FAIL b2b_pulses: got %0d pending want 0", sb_rdata.size());
    end
    req(0, 8'hFF, BASE + 64'd56, 64'd0, 0, 64'd0, 1'b0);
    req(0, 8'hFF, BASE + 64'd48, 64'd0, 0, 64'd0, 1'b0);
  endtask

  task automatic test_reset_mid_resp;
    @(negedge clk);
    bus.acs_en    = 1'b1;
    bus.acs_wr    = 1'b0;
    bus.acs_bytes = 8'hFF;
    bus.acs_addr  = BASE;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.acs_wr    = 1'b1;
    bus.acs_addr  = BASE + 64'd8;
    bus.acs_wdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    total++;
    if (bus.acs_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rst_cancel: got rvalid=%b want 0", bus.acs_rvalid);
    end
    repeat (2) @(posedge clk);
    #1;
    bus.acs_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.acs_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_release_ready: got %b want 1", bus.acs_ready);
    end
    req(0, 8'hFF, BASE, 64'd0, 1, 64'h1122AB4455667788, 1'b0);
    req(0, 8'hFF, BASE + 64'd8, 64'd0, 0, 64'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_misalign();
    test_range();
    test_random();
    test_back_to_back();
    test_reset_mid_resp();
    repeat (2) @(negedge clk);
    total++;
    if (sb_rdata.size() != 0) begin
      bad++;
      $display("FAIL missing_resp: got %0d pending want 0", sb_rdata.size());
    end
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
